// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and tick divider math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Clocks per oversample tick, floored, never below one clock.
    function automatic int tick_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by restart.
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || restart || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    // The restart cycle itself never ticks, so the first tick lands DIV clocks later.
    assign tick = (count == '0) && !restart;

endmodule

// File: rtl/uart_rx_buffer.sv
// 16x-oversampled UART receiver pushing each good byte into a newest-first history RXBUF.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit, rejects glitches
// DATA      | sampling DATA_BITS payload bits, LSB first
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit, commit or flag a frame error
// WAIT_IDLE | bad stop bit seen, waiting for the line to return high
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int FIFO      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 clr,
    output logic [DATA_BITS-1:0] RXBUF [0:FIFO-1],
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic [7:0]           rx_count,
    output logic                 busy
);

    localparam int            TICK_DIV = tick_div(CLK_FREQ, BAUD);
    localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]    TC_MID   = 4'(MID_SAMPLE - 1);
    localparam logic [3:0]    TC_BIT   = 4'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    logic                 restart;
    logic                 sample;
    logic                 commit;
    logic                 reject;
    logic [3:0]           tick_left;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    baud_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (sample) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (sample && bit_idx == LAST_BIT) state_nxt = AFTER_DATA;
            PARITY:    if (sample) state_nxt = STOP;
            STOP:      if (sample) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        restart = (state == IDLE) && !rx_s;
        sample  = tick && (tick_left == '0);
        commit  = (state == STOP) && sample && rx_s && !parity_bad;
        reject  = (state == STOP) && sample && !(rx_s && !parity_bad);
    end

    // tick_left is a down-counter to the next sample point: half a bit first, then whole bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_left <= '0;
            bit_idx   <= '0;
            shift     <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) tick_left <= TC_MID;
                START, DATA, PARITY, STOP: begin
                    if (tick) begin
                        tick_left <= (tick_left == '0) ? TC_BIT : tick_left - 4'd1;
                    end
                end
                default: ;
            endcase
            if (state == START) begin
                bit_idx <= '0;
            end
            if (state == DATA && sample) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + BIT_ONE;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || state == START) begin
            parity_bad <= 1'b0;
        end else if (state == PARITY && sample) begin
            parity_bad <= (rx_s != ^shift);
        end
    end
`else
    assign parity_bad = 1'b0;
`endif

    // clr has priority over a same-cycle commit; the valid pulse is still reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO; i++) RXBUF[i] <= '0;
            rx_count  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= commit;
            frame_err <= reject;
            if (clr) begin
                for (int i = 0; i < FIFO; i++) RXBUF[i] <= '0;
                rx_count <= '0;
            end else if (commit) begin
                for (int i = FIFO - 1; i > 0; i--) RXBUF[i] <= RXBUF[i-1];
                RXBUF[0] <= shift;
                rx_count <= rx_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: frame-level reference model plus directed and random frames.
module tb_uart_rx_buffer;

    localparam int DB      = 8;
    localparam int FIFO    = 4;
    localparam int BIT_CLK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int LAT_LIT  = 171;
`else
    localparam int PAR_BITS = 0;
    localparam int LAT_LIT  = 155;
`endif
    // start edge -> 2 sync flops -> 1 detect cycle -> half bit -> remaining bits through stop
    localparam int LATENCY = 3 + BIT_CLK / 2 + BIT_CLK * (DB + PAR_BITS + 1);

    typedef struct {
        int         at;
        bit         ok;
        logic [7:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          clr;
    logic [DB-1:0] RXBUF [0:FIFO-1];
    logic          rx_valid;
    logic          frame_err;
    logic [7:0]    rx_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_pulses = 0;
    int err_pulses = 0;
    int last_valid_cyc = 0;

    logic [DB-1:0] m_buf [0:FIFO-1];
    int            m_count = 0;
    ev_t           evq[$];

    uart_rx_buffer #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .DATA_BITS (DB),
        .FIFO      (FIFO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .clr       (clr),
        .RXBUF     (RXBUF),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_count  (rx_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, advanced once per clock after the edge.
    initial begin : compare
        ev_t  ev;
        logic exp_v;
        logic exp_e;
        forever begin
            @(posedge clk);
            #1;
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (rst) begin
                evq.delete();
                for (int i = 0; i < FIFO; i++) m_buf[i] = '0;
                m_count = 0;
            end else begin
                if (evq.size() > 0 && evq[0].at == cyc) begin
                    ev = evq.pop_front();
                    if (ev.ok) begin
                        exp_v = 1'b1;
                        for (int i = FIFO - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                        m_buf[0] = ev.data;
                        m_count = (m_count + 1) % 256;
                    end else begin
                        exp_e = 1'b1;
                    end
                end
                if (clr) begin
                    for (int i = 0; i < FIFO; i++) m_buf[i] = '0;
                    m_count = 0;
                end
            end
            check("rx_valid", 32'(rx_valid), 32'(exp_v));
            check("frame_err", 32'(frame_err), 32'(exp_e));
            check("rx_count", 32'(rx_count), 32'(m_count));
            for (int i = 0; i < FIFO; i++) check("RXBUF", 32'(RXBUF[i]), 32'(m_buf[i]));
            if (rx_valid === 1'b1) begin
                valid_pulses++;
                last_valid_cyc = cyc;
            end
            if (frame_err === 1'b1) err_pulses++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: actual timeout required finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // All driving tasks start and end right after a falling edge.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        ev_t e;
        e.at   = cyc + LATENCY;
        e.ok   = stop_ok && (par_ok || PAR_BITS == 0);
        e.data = d;
        evq.push_back(e);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ !par_ok;
        repeat (BIT_CLK) @(negedge clk);
`endif
        rx = stop_ok;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic pulse_clr_after(input int n);
        repeat (n) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    int         t0;
    int         vp0;
    int         ep0;
    logic [7:0] rd;
    bit         s_ok;
    bit         p_ok;
    bit         do_clr;
    int         off;
    int         gap;

    initial begin : stimulus
        rst = 1'b1;
        rx  = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(rx_count), 32'd0);
        check("reset_buf0", 32'(RXBUF[0]), 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(5);

        // 1: single good byte, exact latency from the start edge
        vp0 = valid_pulses;
        t0  = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(5);
        check("t1_latency", 32'(last_valid_cyc - t0), 32'(LAT_LIT));
        check("t1_pulses", 32'(valid_pulses - vp0), 32'd1);
        check("t1_buf0", 32'(RXBUF[0]), 32'hA5);
        check("t1_model_buf0", 32'(m_buf[0]), 32'hA5);
        check("t1_count", 32'(rx_count), 32'd1);
        check("t1_model_count", 32'(m_count), 32'd1);

        // 2: five back-to-back bytes, oldest one falls out
        pulse_clr_after(0);
        idle(3);
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'h44, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(5);
        check("t2_buf0", 32'(RXBUF[0]), 32'h55);
        check("t2_buf1", 32'(RXBUF[1]), 32'h44);
        check("t2_buf2", 32'(RXBUF[2]), 32'h33);
        check("t2_buf3", 32'(RXBUF[3]), 32'h22);
        check("t2_count", 32'(rx_count), 32'd5);

        // 3: bad stop bit followed by a held-low line
        ep0 = err_pulses;
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("t3_busy_low_line", 32'(busy), 32'd1);
            @(negedge clk);
        end
        idle(5);
        check("t3_busy_released", 32'(busy), 32'd0);
        check("t3_err_pulses", 32'(err_pulses - ep0), 32'd1);
        check("t3_buf0", 32'(RXBUF[0]), 32'h55);
        idle(10);

        // 4: short glitch is rejected at mid start bit
        vp0 = valid_pulses;
        ep0 = err_pulses;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("t4_busy_started", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        check("t4_busy_idle", 32'(busy), 32'd0);
        idle(10);
        check("t4_no_valid", 32'(valid_pulses - vp0), 32'd0);
        check("t4_no_err", 32'(err_pulses - ep0), 32'd0);

        // 5: reset in the middle of 0x7E, then a clean 0x81
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rd = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            rx = rd[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        idle(20);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(5);
        check("t5_buf0", 32'(RXBUF[0]), 32'h81);
        check("t5_buf1", 32'(RXBUF[1]), 32'h00);
        check("t5_count", 32'(rx_count), 32'd1);

        // 6: clr lands on the commit cycle of 0x99
        vp0 = valid_pulses;
        fork
            send_frame(8'h99, 1'b1, 1'b1);
            pulse_clr_after(LATENCY - 1);
        join
        idle(5);
        check("t6_pulses", 32'(valid_pulses - vp0), 32'd1);
        check("t6_count", 32'(rx_count), 32'd0);
        for (int i = 0; i < FIFO; i++) check("t6_buf_zero", 32'(RXBUF[i]), 32'd0);

`ifdef UART_RX_PARITY_EN
        vp0 = valid_pulses;
        ep0 = err_pulses;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(5);
        check("par_err_pulses", 32'(err_pulses - ep0), 32'd1);
        check("par_no_commit", 32'(valid_pulses - vp0), 32'd0);
`endif

        // rx_count wraps: 257 commits from zero leave a count of one
        for (int n = 0; n < 257; n++) begin
            rd = 8'($urandom_range(0, 255));
            send_frame(rd, 1'b1, 1'b1);
        end
        idle(5);
        check("wrap_count", 32'(rx_count), 32'd1);
        check("wrap_model_count", 32'(m_count), 32'd1);

        // random mix of good/bad frames, gaps and stray clears
        for (int n = 0; n < 30; n++) begin
            rd     = 8'($urandom_range(0, 255));
            s_ok   = ($urandom_range(0, 5) != 0);
            p_ok   = ($urandom_range(0, 5) != 0);
            do_clr = ($urandom_range(0, 3) == 0);
            off    = $urandom_range(1, 150);
            gap    = s_ok ? $urandom_range(0, 5) : $urandom_range(2, 12);
            fork
                send_frame(rd, s_ok, p_ok);
                if (do_clr) pulse_clr_after(off);
            join
            idle(gap);
        end
        idle(20);
        check("events_drained", 32'(evq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
